adder_rr_arbiter: RTL

ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

---
 rtl/adder_rr_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
// Two requesters share one 33-bit carry-lookahead adder through a round-robin
// arbiter and a two-stage valid/ready pipeline with per-requester grant counters.

module adder_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Second-level lookahead: group carries never ripple through the 4-bit groups.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

module adder_cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [32:0] sum
);
  logic [15:0] sum_lo;
  logic [15:0] sum_hi;
  logic        c_mid;
  logic        c_out;

  adder_cla16 u_lo (
    .a    (a[15:0]),
    .b    (b[15:0]),
    .cin  (1'b0),
    .sum  (sum_lo),
    .cout (c_mid)
  );

  adder_cla16 u_hi (
    .a    (a[31:16]),
    .b    (b[31:16]),
    .cin  (c_mid),
    .sum  (sum_hi),
    .cout (c_out)
  );

  assign sum = {c_out, sum_hi, sum_lo};
endmodule

module adder_rr_arbiter #(
  parameter int RR_INIT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [32:0]      rsp_sum,
  output logic             rsp_id,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);
  localparam int DATA_W = 32;

  logic              prio;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
  logic              gnt0;
  logic              gnt1;
  logic              hs0;
  logic              hs1;
  logic              s1_en;
  logic              s2_en;

  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              id_p1;
  logic              vld_p1;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   sum_p2;
  logic              id_p2;
  logic              vld_p2;

  assign s2_en = ~vld_p2 | rsp_ready;
  assign s1_en = ~vld_p1 | s2_en;

  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~prio);
    gnt1 = req1_valid & (~req0_valid | prio);
  end

  // Readys are forced low while reset is asserted so nothing is accepted then.
  assign req0_ready = gnt0 & s1_en & ~rst;
  assign req1_ready = gnt1 & s1_en & ~rst;
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'(RR_INIT);
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (hs0) begin
        prio <= 1'b1;
        cnt0 <= cnt0 + CNT_W'(1);
      end else if (hs1) begin
        prio <= 1'b0;
        cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end

  // ---- stage p1: granted operands ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_en) begin
      vld_p1 <= hs0 | hs1;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_en && (hs0 || hs1)) begin
      a_p1  <= hs1 ? req1_a : req0_a;
      b_p1  <= hs1 ? req1_b : req0_b;
      id_p1 <= hs1;
    end
  end

  adder_cla32 u_add (
    .a   (a_p1),
    .b   (b_p1),
    .sum (add_sum)
  );

  // ---- stage p2: registered result driving the response port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      sum_p2 <= '0;
      id_p2  <= 1'b0;
    end else if (s2_en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sum_p2 <= add_sum;
        id_p2  <= id_p1;
      end
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_sum   = sum_p2;
  assign rsp_id    = id_p2;
  assign gnt_cnt0  = cnt0;
  assign gnt_cnt1  = cnt1;
endmodule
